// File: rtl/spi_master_arb.sv
// ---------------------------------------------------------------------------
// spi_master_arb
//   Round-robin arbiter and sequencer sharing one SPI master controller
//   between NUM_REQ on-chip requesters. Each grant latches the winner's
//   transaction descriptor, drives the controller configuration, issues one
//   start strobe, routes the TX/RX streams to the winner and holds the grant
//   until the controller reports end-of-transfer.
//
// Optional feature macro: SPI_ARB_TIMEOUT_EN
//   Defined   : BUSY watchdog; on expiry pulses spi_swrst and err_o[g].
//   Undefined : no watchdog, spi_swrst and err_o tied to 0.
//
// Ports
//   HCLK, HRESETn            clock, synchronous active-low reset
//   req_i / gnt_o            per-requester request level / one-hot grant
//   done_o / err_o           per-requester completion / timeout pulses
//   req_op_i .. req_dummy_wr_i  flattened per-requester descriptors
//   req_tx_* / req_rx_*      per-requester data streams
//   spi_cmd .. spi_dummy_wr  registered descriptor copies to the controller
//   spi_csreg                one-hot chip select (0 when idle)
//   spi_rd/wr/qrd/qwr        one-cycle start strobes
//   spi_swrst                controller reset pulse (watchdog only)
//   eot                      end of transfer from the controller
//   spi_ctrl_data_tx* / rx*  controller-side data streams
// ---------------------------------------------------------------------------
module spi_master_arb #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [NUM_REQ-1:0]    req_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic [NUM_REQ-1:0]    done_o,
  output logic [NUM_REQ-1:0]    err_o,
  input  logic [2*NUM_REQ-1:0]  req_op_i,
  input  logic [2*NUM_REQ-1:0]  req_cs_i,
  input  logic [32*NUM_REQ-1:0] req_cmd_i,
  input  logic [6*NUM_REQ-1:0]  req_cmd_len_i,
  input  logic [32*NUM_REQ-1:0] req_addr_i,
  input  logic [6*NUM_REQ-1:0]  req_addr_len_i,
  input  logic [16*NUM_REQ-1:0] req_data_len_i,
  input  logic [16*NUM_REQ-1:0] req_dummy_rd_i,
  input  logic [16*NUM_REQ-1:0] req_dummy_wr_i,
  input  logic [32*NUM_REQ-1:0] req_tx_data_i,
  input  logic [NUM_REQ-1:0]    req_tx_valid_i,
  output logic [NUM_REQ-1:0]    req_tx_ready_o,
  output logic [31:0]           req_rx_data_o,
  output logic [NUM_REQ-1:0]    req_rx_valid_o,
  input  logic [NUM_REQ-1:0]    req_rx_ready_i,
  output logic [31:0]           spi_cmd,
  output logic [5:0]            spi_cmd_len,
  output logic [31:0]           spi_addr,
  output logic [5:0]            spi_addr_len,
  output logic [15:0]           spi_data_len,
  output logic [15:0]           spi_dummy_rd,
  output logic [15:0]           spi_dummy_wr,
  output logic [3:0]            spi_csreg,
  output logic                  spi_rd,
  output logic                  spi_wr,
  output logic                  spi_qrd,
  output logic                  spi_qwr,
  output logic                  spi_swrst,
  input  logic                  eot,
  output logic [31:0]           spi_ctrl_data_tx,
  output logic                  spi_ctrl_data_tx_valid,
  input  logic                  spi_ctrl_data_tx_ready,
  input  logic [31:0]           spi_ctrl_data_rx,
  input  logic                  spi_ctrl_data_rx_valid,
  output logic                  spi_ctrl_data_rx_ready
);

  localparam int PTR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_START = 3'd2,
    ST_BUSY  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t             state_r, state_next_s;
  logic [PTR_W-1:0]   rr_ptr_r, gnt_idx_r, win_idx_s;
  logic               win_found_s;
  logic [NUM_REQ-1:0] gnt_r, done_r, gnt_next_s;
  int                 idx_v;

  // latched descriptor of the current grant
  logic [1:0]  op_r, cs_r;
  logic [31:0] cmd_r, addr_r;
  logic [5:0]  cmd_len_r, addr_len_r;
  logic [15:0] data_len_r, dummy_rd_r, dummy_wr_r;

  // descriptor of the arbitration winner, selected combinationally
  logic [1:0]  sel_op_s, sel_cs_s;
  logic [31:0] sel_cmd_s, sel_addr_s;
  logic [5:0]  sel_cmd_len_s, sel_addr_len_s;
  logic [15:0] sel_data_len_s, sel_dummy_rd_s, sel_dummy_wr_s;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = (TIMEOUT_CYCLES >= 2) ? 16'(TIMEOUT_CYCLES - 2) : 16'd0;
  logic [15:0]        busy_cnt_r;
  logic               timeout_s;
  logic               swrst_r;
  logic [NUM_REQ-1:0] err_r;
`endif

  assign gnt_o  = gnt_r;
  assign done_o = done_r;

  // Round-robin search: first requester at or above rr_ptr, wrapping.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    idx_v       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_v = (int'(rr_ptr_r) + k) % NUM_REQ;
      if (!win_found_s && req_i[idx_v]) begin
        win_found_s = 1'b1;
        win_idx_s   = PTR_W'(idx_v);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Select the winner's descriptor slice and build its one-hot grant.
  always_comb begin
    gnt_next_s     = '0;
    sel_op_s       = 2'd0;
    sel_cs_s       = 2'd0;
    sel_cmd_s      = 32'd0;
    sel_cmd_len_s  = 6'd0;
    sel_addr_s     = 32'd0;
    sel_addr_len_s = 6'd0;
    sel_data_len_s = 16'd0;
    sel_dummy_rd_s = 16'd0;
    sel_dummy_wr_s = 16'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx_s == PTR_W'(i)) begin
        gnt_next_s[i]  = 1'b1;
        sel_op_s       = req_op_i[2*i +: 2];
        sel_cs_s       = req_cs_i[2*i +: 2];
        sel_cmd_s      = req_cmd_i[32*i +: 32];
        sel_cmd_len_s  = req_cmd_len_i[6*i +: 6];
        sel_addr_s     = req_addr_i[32*i +: 32];
        sel_addr_len_s = req_addr_len_i[6*i +: 6];
        sel_data_len_s = req_data_len_i[16*i +: 16];
        sel_dummy_rd_s = req_dummy_rd_i[16*i +: 16];
        sel_dummy_wr_s = req_dummy_wr_i[16*i +: 16];
      end else begin
        gnt_next_s[i]  = 1'b0;
      end
    end
  end

  // Next-state logic of the grant sequencer; eot only matters in BUSY.
  always_comb begin
    state_next_s = state_r;
`ifdef SPI_ARB_TIMEOUT_EN
    timeout_s    = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (win_found_s) state_next_s = ST_GRANT;
        else             state_next_s = ST_IDLE;
      end
      ST_GRANT: state_next_s = ST_START;
      ST_START: state_next_s = ST_BUSY;
      ST_BUSY: begin
        if (eot) begin
          state_next_s = ST_DONE;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        // TO_LAST places spi_swrst exactly TIMEOUT_CYCLES after the strobe
        else if (busy_cnt_r >= TO_LAST) begin
          state_next_s = ST_DONE;
          timeout_s    = 1'b1;
        end
`endif
        else begin
          state_next_s = ST_BUSY;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, grant, descriptor and controller-config registers.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_r      <= ST_IDLE;
      rr_ptr_r     <= '0;
      gnt_idx_r    <= '0;
      gnt_r        <= '0;
      done_r       <= '0;
      op_r         <= 2'd0;
      cs_r         <= 2'd0;
      cmd_r        <= 32'd0;
      cmd_len_r    <= 6'd0;
      addr_r       <= 32'd0;
      addr_len_r   <= 6'd0;
      data_len_r   <= 16'd0;
      dummy_rd_r   <= 16'd0;
      dummy_wr_r   <= 16'd0;
      spi_cmd      <= 32'd0;
      spi_cmd_len  <= 6'd0;
      spi_addr     <= 32'd0;
      spi_addr_len <= 6'd0;
      spi_data_len <= 16'd0;
      spi_dummy_rd <= 16'd0;
      spi_dummy_wr <= 16'd0;
      spi_csreg    <= 4'd0;
      spi_rd       <= 1'b0;
      spi_wr       <= 1'b0;
      spi_qrd      <= 1'b0;
      spi_qwr      <= 1'b0;
    end else begin
      state_r <= state_next_s;
      done_r  <= '0;
      spi_rd  <= 1'b0;
      spi_wr  <= 1'b0;
      spi_qrd <= 1'b0;
      spi_qwr <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (win_found_s) begin
            gnt_r      <= gnt_next_s;
            gnt_idx_r  <= win_idx_s;
            op_r       <= sel_op_s;
            cs_r       <= sel_cs_s;
            cmd_r      <= sel_cmd_s;
            cmd_len_r  <= sel_cmd_len_s;
            addr_r     <= sel_addr_s;
            addr_len_r <= sel_addr_len_s;
            data_len_r <= sel_data_len_s;
            dummy_rd_r <= sel_dummy_rd_s;
            dummy_wr_r <= sel_dummy_wr_s;
          end
        end
        ST_GRANT: begin
          spi_cmd      <= cmd_r;
          spi_cmd_len  <= cmd_len_r;
          spi_addr     <= addr_r;
          spi_addr_len <= addr_len_r;
          spi_data_len <= data_len_r;
          spi_dummy_rd <= dummy_rd_r;
          spi_dummy_wr <= dummy_wr_r;
          spi_csreg    <= 4'b0001 << cs_r;
          // strobe lands in the START cycle, together with valid config
          case (op_r)
            2'b00:   spi_rd  <= 1'b1;
            2'b01:   spi_wr  <= 1'b1;
            2'b10:   spi_qrd <= 1'b1;
            2'b11:   spi_qwr <= 1'b1;
            default: spi_rd  <= 1'b0;
          endcase
        end
        ST_BUSY: begin
          if (state_next_s == ST_DONE) done_r <= gnt_r;
        end
        ST_DONE: begin
          gnt_r     <= '0;
          spi_csreg <= 4'd0;
          rr_ptr_r  <= (gnt_idx_r == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx_r + PTR_W'(1);
        end
        default: gnt_r <= gnt_r;
      endcase
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  // BUSY watchdog counter and the timeout pulses it produces.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      busy_cnt_r <= 16'd0;
      swrst_r    <= 1'b0;
      err_r      <= '0;
    end else begin
      swrst_r <= timeout_s;
      err_r   <= timeout_s ? gnt_r : '0;
      if (state_r == ST_START)     busy_cnt_r <= 16'd0;
      else if (state_r == ST_BUSY) busy_cnt_r <= busy_cnt_r + 16'd1;
      else                         busy_cnt_r <= busy_cnt_r;
    end
  end

  assign spi_swrst = swrst_r;
  assign err_o     = err_r;
`else
  assign spi_swrst = 1'b0;
  assign err_o     = '0;
`endif

  // Stream routing follows the registered grant; no grant means all idle.
  always_comb begin
    spi_ctrl_data_tx       = 32'd0;
    spi_ctrl_data_tx_valid = 1'b0;
    spi_ctrl_data_rx_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_r[i]) begin
        spi_ctrl_data_tx       = req_tx_data_i[32*i +: 32];
        spi_ctrl_data_tx_valid = req_tx_valid_i[i];
        spi_ctrl_data_rx_ready = req_rx_ready_i[i];
      end else begin
        spi_ctrl_data_tx_valid = spi_ctrl_data_tx_valid;
      end
    end
  end

  assign req_tx_ready_o = gnt_r & {NUM_REQ{spi_ctrl_data_tx_ready}};
  assign req_rx_valid_o = gnt_r & {NUM_REQ{spi_ctrl_data_rx_valid}};
  assign req_rx_data_o  = (|gnt_r) ? spi_ctrl_data_rx : 32'd0;

endmodule

// File: tb/tb_spi_master_arb.sv
// Testbench for spi_master_arb (NUM_REQ = 2): reset state, a table of
// hand-computed transactions, hand-written corner sequences and a random
// phase checked against a transaction-level round-robin model.
module tb_spi_master_arb;

  localparam int NR = 2;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 65535;
`endif

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic [NR-1:0] req_i, gnt_o, done_o, err_o;
  logic [2*NR-1:0]  req_op_i, req_cs_i;
  logic [32*NR-1:0] req_cmd_i, req_addr_i, req_tx_data_i;
  logic [6*NR-1:0]  req_cmd_len_i, req_addr_len_i;
  logic [16*NR-1:0] req_data_len_i, req_dummy_rd_i, req_dummy_wr_i;
  logic [NR-1:0] req_tx_valid_i, req_tx_ready_o, req_rx_valid_o, req_rx_ready_i;
  logic [31:0]   req_rx_data_o;
  logic [31:0]   spi_cmd, spi_addr;
  logic [5:0]    spi_cmd_len, spi_addr_len;
  logic [15:0]   spi_data_len, spi_dummy_rd, spi_dummy_wr;
  logic [3:0]    spi_csreg;
  logic          spi_rd, spi_wr, spi_qrd, spi_qwr, spi_swrst, eot;
  logic [31:0]   spi_ctrl_data_tx, spi_ctrl_data_rx;
  logic          spi_ctrl_data_tx_valid, spi_ctrl_data_tx_ready;
  logic          spi_ctrl_data_rx_valid, spi_ctrl_data_rx_ready;
  logic [3:0]    strb;

  assign strb = {spi_qwr, spi_qrd, spi_wr, spi_rd};

  spi_master_arb #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_i(req_i), .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o),
    .req_op_i(req_op_i), .req_cs_i(req_cs_i),
    .req_cmd_i(req_cmd_i), .req_cmd_len_i(req_cmd_len_i),
    .req_addr_i(req_addr_i), .req_addr_len_i(req_addr_len_i),
    .req_data_len_i(req_data_len_i), .req_dummy_rd_i(req_dummy_rd_i),
    .req_dummy_wr_i(req_dummy_wr_i),
    .req_tx_data_i(req_tx_data_i), .req_tx_valid_i(req_tx_valid_i),
    .req_tx_ready_o(req_tx_ready_o),
    .req_rx_data_o(req_rx_data_o), .req_rx_valid_o(req_rx_valid_o),
    .req_rx_ready_i(req_rx_ready_i),
    .spi_cmd(spi_cmd), .spi_cmd_len(spi_cmd_len), .spi_addr(spi_addr),
    .spi_addr_len(spi_addr_len), .spi_data_len(spi_data_len),
    .spi_dummy_rd(spi_dummy_rd), .spi_dummy_wr(spi_dummy_wr),
    .spi_csreg(spi_csreg), .spi_rd(spi_rd), .spi_wr(spi_wr),
    .spi_qrd(spi_qrd), .spi_qwr(spi_qwr), .spi_swrst(spi_swrst), .eot(eot),
    .spi_ctrl_data_tx(spi_ctrl_data_tx),
    .spi_ctrl_data_tx_valid(spi_ctrl_data_tx_valid),
    .spi_ctrl_data_tx_ready(spi_ctrl_data_tx_ready),
    .spi_ctrl_data_rx(spi_ctrl_data_rx),
    .spi_ctrl_data_rx_valid(spi_ctrl_data_rx_valid),
    .spi_ctrl_data_rx_ready(spi_ctrl_data_rx_ready)
  );

  always #5 HCLK = ~HCLK;

  int n_vec = 0;
  int n_err = 0;
  int rr_m  = 0;   // model round-robin pointer

  // bench-side copy of each requester's descriptor
  logic [1:0]  d_op[NR], d_cs[NR];
  logic [31:0] d_cmd[NR], d_addr[NR];
  logic [5:0]  d_cmd_len[NR], d_addr_len[NR];
  logic [15:0] d_dlen[NR], d_drd[NR], d_dwr[NR];

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  op0, op1, cs0, cs1;
    logic [31:0] cmd0, cmd1;
    int          eot_dly;
    logic [1:0]  exp_gnt;
    logic [3:0]  exp_strb;
    logic [3:0]  exp_cs;
    logic [31:0] exp_cmd;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive_desc();
    for (int i = 0; i < NR; i++) begin
      req_op_i[2*i +: 2]         = d_op[i];
      req_cs_i[2*i +: 2]         = d_cs[i];
      req_cmd_i[32*i +: 32]      = d_cmd[i];
      req_cmd_len_i[6*i +: 6]    = d_cmd_len[i];
      req_addr_i[32*i +: 32]     = d_addr[i];
      req_addr_len_i[6*i +: 6]   = d_addr_len[i];
      req_data_len_i[16*i +: 16] = d_dlen[i];
      req_dummy_rd_i[16*i +: 16] = d_drd[i];
      req_dummy_wr_i[16*i +: 16] = d_dwr[i];
    end
  endtask

  task automatic rand_desc();
    for (int i = 0; i < NR; i++) begin
      d_op[i]       = 2'($urandom_range(0, 3));
      d_cs[i]       = 2'($urandom_range(0, 3));
      d_cmd[i]      = $urandom;
      d_cmd_len[i]  = 6'($urandom_range(0, 32));
      d_addr[i]     = $urandom;
      d_addr_len[i] = 6'($urandom_range(0, 32));
      d_dlen[i]     = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      d_drd[i]      = 16'($urandom_range(0, 15));
      d_dwr[i]      = 16'($urandom_range(0, 15));
    end
  endtask

  // Reference arbitration: first set request at or above the pointer, wrapping.
  function automatic int model_winner(input logic [NR-1:0] req, input int rr);
    for (int k = 0; k < NR; k++) begin
      if (req[(rr + k) % NR]) return (rr + k) % NR;
    end
    return 0;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},   64'(gnt_o), 64'd0);
    chk({tag, "_done"},  64'(done_o), 64'd0);
    chk({tag, "_err"},   64'({err_o, spi_swrst}), 64'd0);
    chk({tag, "_strb"},  64'(strb), 64'd0);
    chk({tag, "_cs"},    64'(spi_csreg), 64'd0);
    chk({tag, "_cmd"},   64'({spi_cmd, spi_addr}), 64'd0);
    chk({tag, "_lens"},  64'({spi_cmd_len, spi_addr_len, spi_data_len, spi_dummy_rd, spi_dummy_wr}), 64'd0);
    chk({tag, "_rq_st"}, 64'({req_tx_ready_o, req_rx_valid_o, req_rx_data_o}), 64'd0);
    chk({tag, "_ct_st"}, 64'({spi_ctrl_data_tx, spi_ctrl_data_tx_valid, spi_ctrl_data_rx_ready}), 64'd0);
  endtask

  // Non-winner floods its TX stream with 0xDEADBEEF; only the winner may pass.
  task automatic stream_check(input int w);
    logic [31:0] wd, rd;
    logic        wv, cr, rv;
    logic [NR-1:0] rr_rdy, oh;
    wd = $urandom; rd = $urandom;
    wv = 1'($urandom_range(0, 1)); cr = 1'($urandom_range(0, 1));
    rv = 1'($urandom_range(0, 1)); rr_rdy = NR'($urandom_range(0, 3));
    oh = NR'(1) << w;
    for (int i = 0; i < NR; i++) begin
      req_tx_data_i[32*i +: 32] = (i == w) ? wd : 32'hDEADBEEF;
      req_tx_valid_i[i]         = (i == w) ? wv : 1'b1;
    end
    req_rx_ready_i         = rr_rdy;
    spi_ctrl_data_tx_ready = cr;
    spi_ctrl_data_rx       = rd;
    spi_ctrl_data_rx_valid = rv;
    #1;
    chk("tx_data", 64'(spi_ctrl_data_tx), 64'(wd));
    chk("tx_v_rx_r", 64'({spi_ctrl_data_tx_valid, spi_ctrl_data_rx_ready}), 64'({wv, rr_rdy[w]}));
    chk("tx_ready", 64'(req_tx_ready_o), cr ? 64'(oh) : 64'd0);
    chk("rx_valid", 64'(req_rx_valid_o), rv ? 64'(oh) : 64'd0);
    chk("rx_data", 64'(req_rx_data_o), 64'(rd));
  endtask

  // One complete transaction, starting in an IDLE cycle.
  task automatic run_txn(input logic [NR-1:0] req, input logic [NR-1:0] exp_gnt,
                         input logic [3:0] exp_strb, input logic [3:0] exp_cs,
                         input logic [31:0] exp_cmd, input int eot_dly,
                         input bit change_desc, input bit early_eot);
    int w;
    logic [31:0] e_addr;
    logic [43:0] e_lens;
    logic [15:0] e_dwr;
    w = 0;
    for (int i = 0; i < NR; i++) if (exp_gnt[i]) w = i;
    e_addr = d_addr[w];
    e_lens = {d_cmd_len[w], d_addr_len[w], d_dlen[w], d_drd[w]};
    e_dwr  = d_dwr[w];
    req_i = req;
    drive_desc();
    tick();
    chk("gnt", 64'(gnt_o), 64'(exp_gnt));
    chk("done_at_gnt", 64'(done_o), 64'd0);
    if (change_desc) begin
      rand_desc();
      for (int i = 0; i < NR; i++) d_cmd[i] = 32'h0000009F;
      drive_desc();
      req_i = NR'($urandom_range(0, 3));
    end
    eot = early_eot;
    tick();
    chk("strobe", 64'(strb), 64'(exp_strb));
    chk("csreg", 64'(spi_csreg), 64'(exp_cs));
    chk("cmd", 64'(spi_cmd), 64'(exp_cmd));
    chk("addr", 64'(spi_addr), 64'(e_addr));
    chk("lens", 64'({spi_cmd_len, spi_addr_len, spi_data_len, spi_dummy_rd}), 64'(e_lens));
    chk("dummy_wr", 64'(spi_dummy_wr), 64'(e_dwr));
    tick();
    eot = 1'b0;
    chk("strobe_off", 64'(strb), 64'd0);
    chk("busy_gnt_done", 64'({gnt_o, done_o}), 64'({exp_gnt, {NR{1'b0}}}));
    stream_check(w);
    chk("no_err", 64'({err_o, spi_swrst}), 64'd0);
    for (int k = 0; k < eot_dly; k++) begin
      tick();
      chk("busy_no_done", 64'(done_o), 64'd0);
    end
    eot = 1'b1;
    tick();
    eot = 1'b0;
    chk("done", 64'({gnt_o, done_o}), 64'({exp_gnt, exp_gnt}));
    tick();
    chk("idle_gnt_done", 64'({gnt_o, done_o}), 64'd0);
    chk("idle_cs", 64'(spi_csreg), 64'd0);
    chk("idle_cmd_hold", 64'(spi_cmd), 64'(exp_cmd));
    req_i = '0;
    rr_m  = (w + 1) % NR;
  endtask

  initial begin
    int w;
    logic [NR-1:0] rq;
    int cnt;
    bit found;

    // ---- reset with junk on every input ----
    HRESETn = 1'b0; req_i = '1; eot = 1'b1;
    rand_desc(); drive_desc();
    req_tx_data_i = '1; req_tx_valid_i = '1; req_rx_ready_i = '1;
    spi_ctrl_data_tx_ready = 1'b1; spi_ctrl_data_rx = 32'hA5A5A5A5;
    spi_ctrl_data_rx_valid = 1'b1;
    tick(); tick();
    chk_all_zero("rst");
    HRESETn = 1'b1; req_i = '0; eot = 1'b0;
    tick();
    chk("idle_no_req", 64'(gnt_o), 64'd0);

    // ---- table of hand-computed transactions (pointer starts at 0) ----
    tbl[0] = '{2'b01, 2'b00, 2'b00, 2'd2, 2'd0, 32'h03, 32'h00, 2, 2'b01, 4'b0001, 4'b0100, 32'h03};
    tbl[1] = '{2'b11, 2'b01, 2'b11, 2'd3, 2'd1, 32'h02, 32'h32, 1, 2'b10, 4'b1000, 4'b0010, 32'h32};
    tbl[2] = '{2'b11, 2'b01, 2'b11, 2'd3, 2'd1, 32'h02, 32'h32, 3, 2'b01, 4'b0010, 4'b1000, 32'h02};
    tbl[3] = '{2'b11, 2'b01, 2'b10, 2'd3, 2'd0, 32'h02, 32'hEB, 0, 2'b10, 4'b0100, 4'b0001, 32'hEB};
    tbl[4] = '{2'b10, 2'b01, 2'b00, 2'd3, 2'd1, 32'h02, 32'h9F, 1, 2'b10, 4'b0001, 4'b0010, 32'h9F};
    tbl[5] = '{2'b01, 2'b11, 2'b00, 2'd0, 2'd1, 32'h38, 32'h9F, 0, 2'b01, 4'b1000, 4'b0001, 32'h38};
    tbl[6] = '{2'b01, 2'b10, 2'b00, 2'd1, 2'd1, 32'h6B, 32'h9F, 2, 2'b01, 4'b0100, 4'b0010, 32'h6B};
    tbl[7] = '{2'b11, 2'b10, 2'b01, 2'd1, 2'd3, 32'h6B, 32'h05, 1, 2'b10, 4'b0010, 4'b1000, 32'h05};
    for (int t = 0; t < 8; t++) begin
      rand_desc();
      d_op[0] = tbl[t].op0;  d_op[1] = tbl[t].op1;
      d_cs[0] = tbl[t].cs0;  d_cs[1] = tbl[t].cs1;
      d_cmd[0] = tbl[t].cmd0; d_cmd[1] = tbl[t].cmd1;
      d_cmd_len[0] = 6'd8; d_dlen[0] = 16'd32; d_dlen[1] = 16'd0;
      run_txn(tbl[t].req, tbl[t].exp_gnt, tbl[t].exp_strb, tbl[t].exp_cs,
              tbl[t].exp_cmd, tbl[t].eot_dly, 1'b0, 1'b0);
    end

    // ---- descriptor latching: cmd 0xEB changes to 0x9F after grant ----
    rand_desc();
    d_op[1] = 2'b10; d_cs[1] = 2'd0; d_cmd[1] = 32'hEB;
    run_txn(2'b10, 2'b10, 4'b0100, 4'b0001, 32'hEB, 2, 1'b1, 1'b0);

    // ---- eot outside BUSY is ignored (IDLE, GRANT, START) ----
    eot = 1'b1;
    tick();
    eot = 1'b0;
    chk("eot_idle", 64'({gnt_o, done_o}), 64'd0);
    rand_desc();
    d_op[0] = 2'b01; d_cs[0] = 2'd3; d_cmd[0] = 32'h02;
    run_txn(2'b01, 2'b01, 4'b0010, 4'b1000, 32'h02, 2, 1'b0, 1'b1);

    // ---- reset mid-BUSY while requester 1 holds the grant (pointer 1) ----
    rand_desc();
    drive_desc();
    req_i = 2'b11;
    tick();
    chk("pre_rst_gnt", 64'(gnt_o), 64'(2'b10));
    tick(); tick(); tick();
    HRESETn = 1'b0;
    tick();
    chk_all_zero("midrst");
    HRESETn = 1'b1;
    req_i = '0;
    tick();
    chk("post_rst_idle", 64'({gnt_o, done_o}), 64'd0);
    rr_m = 0;
    run_txn(2'b11, 2'b01, 4'b0001 << d_op[0], 4'b0001 << d_cs[0], d_cmd[0], 1, 1'b0, 1'b0);

`ifdef SPI_ARB_TIMEOUT_EN
    // ---- watchdog: eot never comes ----
    rand_desc(); drive_desc();
    req_i = 2'b01;
    w = model_winner(req_i, rr_m);
    tick();
    chk("to_gnt", 64'(gnt_o), 64'(NR'(1) << w));
    tick();
    req_i = '0;
    cnt = 0; found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      tick();
      cnt++;
      if (spi_swrst) found = 1'b1;
    end
    chk("to_cycles", 64'(cnt), 64'(TO));
    chk("to_err_done", 64'({err_o, done_o}), 64'({NR'(1) << w, NR'(1) << w}));
    tick();
    chk("to_idle", 64'({gnt_o, done_o, err_o, spi_swrst}), 64'd0);
    rr_m = (w + 1) % NR;
`endif

    // ---- random transactions against the round-robin model ----
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        req_i = '0;
        tick();
        chk("rand_idle", 64'(gnt_o), 64'd0);
      end
      rand_desc();
      rq = NR'($urandom_range(1, 3));
      w  = model_winner(rq, rr_m);
      run_txn(rq, NR'(1) << w, 4'b0001 << d_op[w], 4'b0001 << d_cs[w], d_cmd[w],
              int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_master_arb.md
# spi_master_arb

Round-robin arbiter and sequencer that shares one `spi_master_controller` (and its TX/RX FIFO streams) between `NUM_REQ` on-chip requesters, such as a flash XIP engine and a DMA channel.
- Per grant, it latches the winning requester's transaction descriptor and drives the controller's configuration inputs.
- It issues exactly one start strobe and routes the data streams to the winner.
- It holds the grant until end-of-transfer, then releases the controller.
- It sits between the requesters and the controller, in place of the register-file drive used for software-initiated transfers.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, 2..4.
- `TIMEOUT_CYCLES`, 65535: watchdog limit (only with `SPI_ARB_TIMEOUT_EN`).

Clock and reset:
- `HCLK` in 1: the single clock.
- `HRESETn` in 1: synchronous, active-low reset.

Requester side (vectors are flattened per requester, requester i at slice i):
- `req_i` in NUM_REQ: transaction request, level.
- `gnt_o` out NUM_REQ: one-hot grant.
- `done_o` out NUM_REQ: 1-cycle completion pulse.
- `err_o` out NUM_REQ: 1-cycle timeout pulse, coincident with `done_o`.
- `req_op_i` in 2*NUM_REQ: operation, 00 rd, 01 wr, 10 qrd, 11 qwr.
- `req_cs_i` in 2*NUM_REQ: chip-select index 0..3.
- `req_cmd_i` in 32*NUM_REQ, `req_cmd_len_i` in 6*NUM_REQ: command word and length.
- `req_addr_i` in 32*NUM_REQ, `req_addr_len_i` in 6*NUM_REQ: address and length.
- `req_data_len_i` in 16*NUM_REQ, `req_dummy_rd_i` in 16*NUM_REQ, `req_dummy_wr_i` in 16*NUM_REQ: data length and dummy counts.
- `req_tx_data_i` in 32*NUM_REQ, `req_tx_valid_i` in NUM_REQ, `req_tx_ready_o` out NUM_REQ: TX stream.
- `req_rx_data_o` out 32, `req_rx_valid_o` out NUM_REQ, `req_rx_ready_i` in NUM_REQ: RX stream.

Controller side:
- `spi_cmd` out 32, `spi_cmd_len` out 6, `spi_addr` out 32, `spi_addr_len` out 6: registered copies of the latched descriptor.
- `spi_data_len` out 16, `spi_dummy_rd` out 16, `spi_dummy_wr` out 16: registered copies of the latched descriptor.
- `spi_csreg` out 4: one-hot chip select.
- `spi_rd`, `spi_wr`, `spi_qrd`, `spi_qwr` out 1 each: start strobes.
- `spi_swrst` out 1: controller reset pulse.
- `eot` in 1: end of transfer from the controller.
- `spi_ctrl_data_tx` out 32, `spi_ctrl_data_tx_valid` out 1, `spi_ctrl_data_tx_ready` in 1: TX stream to the controller.
- `spi_ctrl_data_rx` in 32, `spi_ctrl_data_rx_valid` in 1, `spi_ctrl_data_rx_ready` out 1: RX stream from the controller.

## Operation
States: IDLE, GRANT, START, BUSY, DONE.
- **IDLE**:
  - If any `req_i` is set, pick the first set bit at or above `rr_ptr`, wrapping around.
  - Register one-hot `gnt_o` and latch that requester's descriptor into internal registers.
  - Go to GRANT.
- **GRANT**:
  - Descriptor registers now drive the `spi_*` config outputs.
  - `spi_csreg` = 1 << cs.
  - Go to START.
- **START**:
  - Pulse exactly one strobe, selected by op, for one cycle.
  - Go to BUSY.
- **BUSY**:
  - TX/RX streams are muxed to the granted requester.
  - Non-granted requesters see `req_tx_ready_o` = 0 and `req_rx_valid_o` = 0.
  - `req_rx_data_o` is broadcast.
  - On `eot`, go to DONE.
- **DONE**:
  - Pulse `done_o[g]`.
  - Set `rr_ptr` = (g+1) mod NUM_REQ.
  - Clear `gnt_o`.
  - Go to IDLE.

Rules:
- The descriptor is latched once at grant. Requester input changes after grant are ignored.
- `req_i` deasserting after grant does not abort the transfer.
- `eot` outside BUSY is ignored.
- Config outputs hold their last values in IDLE; `spi_csreg` returns to 0.
- Streams are pure combinational muxes on the registered grant; valid/ready semantics pass through unchanged.
- `data_len` = 0 is legal; completion is still signalled by `eot`.

## Timing
- **Reset**: all outputs 0; state IDLE; `rr_ptr` 0; descriptor registers 0.
- **Reset mid-transfer**: IDLE on the next edge, no `done_o`, no `spi_swrst`.
- **Latency**:
  - `req_i` sampled in cycle N → `gnt_o` at N+1.
  - Config valid at N+2.
  - Strobe at N+2, one cycle wide.
  - `eot` at cycle M → `done_o` at M+1, IDLE at M+2.
  - The earliest next grant is at M+3.
- **Simultaneous requests**: resolved by round-robin only. No requester waits more than NUM_REQ-1 transfers.
- **Request during BUSY/DONE**: held pending; arbitrated in the next IDLE with the updated `rr_ptr`.

## Configuration
Macro: `SPI_ARB_TIMEOUT_EN`.
- **Defined**:
  - A 16-bit counter clears on START and increments each BUSY cycle.
  - Reaching `TIMEOUT_CYCLES` without `eot` pulses `spi_swrst` for one cycle and goes to DONE.
  - In that DONE, both `err_o[g]` and `done_o[g]` pulse.
- **Undefined**:
  - No counter is built.
  - `spi_swrst` and `err_o` are tied to 0.
  - BUSY waits for `eot` indefinitely.

## Test plan
- **Single read**: NUM_REQ=2; `req_i`=01, op=00, cs=2, cmd=0x03, cmd_len=8, data_len=32 → `gnt_o`=01 next cycle, `spi_rd` one cycle later with `spi_csreg`=0100, and `done_o[0]` one cycle after `eot`.
- **Contention**: `req_i`=11 held continuously → grants alternate 01, 10, 01. Each new grant appears 3 cycles after the previous `eot`.
- **Stream isolation**: during a qwr granted to requester 1, requester 0 drives `req_tx_valid_i` with 0xDEADBEEF → `spi_ctrl_data_tx` carries only requester 1's words; `req_tx_ready_o[0]` stays 0.
- **Descriptor latching**: change `req_cmd_i[1]` from 0xEB to 0x9F one cycle after grant → `spi_cmd` stays 0xEB until the next grant.
- **Timeout** (macro defined, TIMEOUT_CYCLES=100, `eot` never asserted) → `spi_swrst` pulses 100 cycles after the strobe. `err_o[g]` and `done_o[g]` pulse together, then the FSM returns to IDLE.
- **Reset mid-BUSY**: drive `HRESETn`=0 for one edge → all outputs 0 and `rr_ptr`=0 on that edge; no `done_o` pulse.
